// File: rtl/vga_timing_counter.sv
// vga_timing_counter: divides clk to the pixel rate and generates raster h/v counts,
// pixel/line/frame strobes and a wrapping completed-frame counter.
module vga_timing_counter #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CLK_DIV = 2,
    parameter int FRAME_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [9:0]         h_count,
    output logic [9:0]         v_count,
    output logic               pixel_tick,
    output logic               line_end,
    output logic               frame_end,
    output logic [FRAME_W-1:0] frame_count
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    logic [DW-1:0]      div_q, div_d;
    logic [9:0]         h_q, h_d, v_q, v_d;
    logic [FRAME_W-1:0] fc_q, fc_d;
    // rst_n gating keeps strobes low in reset even when CLK_DIV=1 makes the divider decode constant
    assign pixel_tick  = en && rst_n && (div_q == DIV_LAST);
    assign line_end    = pixel_tick && (h_q == H_LAST);
    assign frame_end   = line_end && (v_q == V_LAST);
    assign h_count     = h_q;
    assign v_count     = v_q;
    assign frame_count = fc_q;
    always_comb begin
        div_d = !en ? div_q : (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        h_d   = !pixel_tick ? h_q : line_end ? '0 : h_q + 10'd1;
        v_d   = !line_end ? v_q : frame_end ? '0 : v_q + 10'd1;
        fc_d  = frame_end ? fc_q + FRAME_W'(1) : fc_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            fc_q  <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            fc_q  <= fc_d;
        end
    end
endmodule

// File: tb/tb_vga_timing_counter.sv
// tb_vga_timing_counter: three parameterisations driven with random enable/reset traffic,
// each checked every cycle against a model derived from the count of enabled clocks.
module tb_vga_timing_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    function automatic int p_h(int k); return k == 0 ? 800 : k == 1 ? 4 : 7; endfunction
    function automatic int p_v(int k); return k == 0 ? 525 : 3; endfunction
    function automatic int p_d(int k); return k == 0 ? 2 : k == 1 ? 1 : 3; endfunction
    function automatic int p_f(int k); return k == 0 ? 8 : k == 1 ? 2 : 3; endfunction
    typedef struct {
        int h;
        int v;
        int fc;
        bit tick;
        bit le;
        bit fe;
    } exp_t;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int H = p_h(g);
        localparam int V = p_v(g);
        localparam int D = p_d(g);
        localparam int FW = p_f(g);
        logic rst_n = 1'b0;
        logic en = 1'b0;
        logic [9:0] hc, vc;
        logic tick, le, fe;
        logic [FW-1:0] fc;
        exp_t q[$];
        longint e = 0;
        bit cur_en = 0;
        bit cur_rst = 0;
        bit stim_done = 0;
        vga_timing_counter #(.H_TOTAL(H), .V_TOTAL(V), .CLK_DIV(D), .FRAME_W(FW)) dut (
            .clk(clk), .rst_n(rst_n), .en(en), .h_count(hc), .v_count(vc),
            .pixel_tick(tick), .line_end(le), .frame_end(fe), .frame_count(fc)
        );
        // e = enabled clocks since the last reset; every position follows from it by arithmetic
        task automatic step(input bit ni_en, input bit ni_rst, input bit pulse);
            exp_t x;
            longint t;
            @(posedge clk);
            e = cur_rst ? e + longint'(cur_en) : 0;
            #1;
            en = ni_en;
            rst_n = pulse ? 1'b0 : ni_rst;
            cur_en = ni_en;
            cur_rst = pulse ? 1'b1 : ni_rst;
            if (!rst_n) e = 0;
            t = e / D;
            x.h = int'(t % H);
            x.v = int'((t / H) % V);
            x.fc = int'((t / (H * V)) % (longint'(1) << FW));
            x.tick = rst_n && ni_en && (e % D == D - 1);
            x.le = x.tick && x.h == H - 1;
            x.fe = x.le && x.v == V - 1;
            q.push_back(x);
            if (pulse) begin
                #6;
                rst_n = 1'b1;
            end
        endtask
        initial begin
            int run;
            run = (H * V * D <= 200) ? ((1 << FW) + 2) * H * V * D : H * D + 100;
            repeat (3) step(1, 0, 0);
            repeat (300) step($urandom_range(0, 9) != 0, 1, 0);
            repeat (2) step(1, 0, 0);
            repeat (run) step(1, 1, 0);
            for (int i = 0; i < D && (e + longint'(cur_en)) % D != D - 1; i++) step(1, 1, 0);
            repeat (37) step(0, 1, 0);
            repeat (50) step(1, 1, 0);
            repeat (20) step(1, 1, 0);
            step(1, 1, 1);
            repeat (run / 2 + 20) step(1, 1, 0);
            repeat (1500) step($urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0, $urandom_range(0, 299) == 0);
            @(negedge clk);
            #1;
            stim_done = 1;
        end
        initial begin
            exp_t x;
            forever begin
                @(negedge clk);
                if (q.size() > 0) begin
                    x = q.pop_front();
                    checks++;
                    if (int'(hc) != x.h || int'(vc) != x.v || int'(fc) != x.fc ||
                        tick !== x.tick || le !== x.le || fe !== x.fe) begin
                        failures++;
                        $display("FAIL dut%0d t=%0t got h=%0d v=%0d fc=%0d tick=%b le=%b fe=%b want h=%0d v=%0d fc=%0d tick=%b le=%b fe=%b",
                                 g, $time, hc, vc, fc, tick, le, fe, x.h, x.v, x.fc, x.tick, x.le, x.fe);
                    end
                end
            end
        end
    end
    initial begin
        bit all_done;
        all_done = 0;
        for (int i = 0; i < 60000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_dut[0].stim_done && g_dut[1].stim_done && g_dut[2].stim_done;
        end
        checks++;
        if (!all_done) begin
            failures++;
            $display("FAIL timeout: stimulus done=%b required 1", all_done);
        end
        checks++;
        if (g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size() != 0) begin
            failures++;
            $display("FAIL drain: unchecked entries=%0d required 0",
                     g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_timing_counter.md
# vga_timing_counter

Free-running raster position generator that sits directly upstream of the VGA sync decoder. It divides the system clock down to the pixel rate and produces `h_count`/`v_count`, which feed the decoder's count inputs. It also emits per-pixel, end-of-line and end-of-frame strobes and a wrapping frame counter for animation logic. Defaults give 640x480@60 Hz (800x525 total) from a 50 MHz clock.

## Interface
Parameters:
- `H_TOTAL`, 800: pixels per line, including blanking; range 2..1024.
- `V_TOTAL`, 525: lines per frame, including blanking; range 2..1024.
- `CLK_DIV`, 2: system clocks per pixel; range 1..16.
- `FRAME_W`, 8: width of `frame_count`.

Ports:
- `clk`  in  1: system clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous active-low reset, released synchronously to `clk` upstream.
- `en`  in  1: count enable; low freezes all state.
- `h_count`  out  10: horizontal position, 0..H_TOTAL-1, registered.
- `v_count`  out  10: vertical position, 0..V_TOTAL-1, registered.
- `pixel_tick`  out  1: one-`clk` strobe; `h_count` advances on the edge that ends it.
- `line_end`  out  1: `pixel_tick` while `h_count`==H_TOTAL-1.
- `frame_end`  out  1: `line_end` while `v_count`==V_TOTAL-1.
- `frame_count`  out  FRAME_W: completed frames, modulo 2^FRAME_W, registered.

## Operation
- Internal divider `div_cnt` (width ceil(log2(CLK_DIV)), minimum 1) counts 0..CLK_DIV-1 while `en`=1, then wraps to 0.
- `pixel_tick` = `en` && (`div_cnt`==CLK_DIV-1). This is a combinational decode of registered state and `en`.
  - CLK_DIV=1: `pixel_tick` = `en`.
- On each `pixel_tick`:
  - `h_count` increments; at H_TOTAL-1 it wraps to 0 and `v_count` increments.
  - `v_count` at V_TOTAL-1 with `line_end` wraps to 0 and `frame_count` increments.
  - `frame_count` wraps from 2^FRAME_W-1 to 0.
- `line_end` and `frame_end` are combinational decodes, asserted in the same cycle as the qualifying `pixel_tick`.
- Counts never leave range; no out-of-range state is reachable from reset.
- `en`=0: `div_cnt`, `h_count`, `v_count` and `frame_count` hold; all strobes are 0. Resuming continues from the held `div_cnt` with no lost or extra tick.
- Reset (asynchronous, at any time, including mid-line or mid-frame):
  - `div_cnt`, `h_count`, `v_count` and `frame_count` are 0.
  - Strobes are 0 while `rst_n`=0.
- Downstream consumers sample counts in the cycle where `pixel_tick`=1, or use the counts directly at pixel rate.

## Timing
- Reset release with `en`=1 held, CLK_DIV=2: first `pixel_tick` is in the 2nd cycle. `h_count` reads 1 after the 2nd rising edge.
- General case: first tick in cycle CLK_DIV after release.
- Line period: H_TOTAL·CLK_DIV clocks (default 1600).
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clocks (default 840 000).
- `line_end` pulses exactly once per line; `frame_end` exactly once per frame; each pulse is one clock wide.
- Output register update latency: 1 clock after the `pixel_tick` cycle.
- `frame_count` increments on the same edge that wraps `v_count` to 0.
- Simultaneous `en` falling in a cycle with `div_cnt`==CLK_DIV-1: no tick; state holds.

## Test plan
- Reset/first tick: assert `rst_n`=0 with counters mid-frame, release, `en`=1, defaults.
  - Outputs read 0 during reset.
  - `pixel_tick` high in cycles 2, 4, 6…; `h_count`=1 after cycle 2.
- Line wrap: run 1600 clocks from reset.
  - `line_end` is high exactly once, at `h_count`=799.
  - Next state is `h_count`=0, `v_count`=1.
- Frame wrap: run 840 000 clocks.
  - `frame_end` is high once, with `h_count`=799 and `v_count`=524.
  - Next state is both counts 0, `frame_count`=1.
  - Count `line_end` pulses = 525.
- Enable hold: drop `en` for 37 clocks mid-line at `div_cnt`=1.
  - All state frozen and strobes 0.
  - After re-enable, first tick comes in the first `en` cycle.
  - Total ticks over the window equal enabled clocks/2.
- Async reset mid-operation: pulse `rst_n` low for less than one clock at `h_count`=400, `v_count`=200.
  - Counts read 0 immediately, without waiting for a clock edge.
  - Restart timing matches scenario 1.
- Parameter corners: CLK_DIV=1, H_TOTAL=4, V_TOTAL=3, FRAME_W=2.
  - `pixel_tick` is high every clock.
  - Frame period is 12 clocks.
  - `frame_count` wraps 3→0 after 4 frames.
